// File: rtl/multi_debouncer_if.sv
// Key inputs and debounced outputs of multi_debouncer, bundled as one port.
// The debouncer connects through the slave modport and the key source through the master modport.
interface multi_debouncer_if #(
   parameter int CHANNELS = 4
);
   logic [CHANNELS-1:0] key_i;
   logic [CHANNELS-1:0] key_state_o;
   logic [CHANNELS-1:0] key_pressed_stb_o;
   logic [CHANNELS-1:0] key_released_stb_o;
   logic                any_pressed_stb_o;

   modport master (
      output key_i,
      input  key_state_o,
      input  key_pressed_stb_o,
      input  key_released_stb_o,
      input  any_pressed_stb_o
   );

   modport slave (
      input  key_i,
      output key_state_o,
      output key_pressed_stb_o,
      output key_released_stb_o,
      output any_pressed_stb_o
   );
endinterface

// File: rtl/multi_debouncer.sv
// Independent per-channel key debouncer: 2-flop synchroniser, then a stable-time counter
// that accepts a new level only after G consecutive cycles that differ from the held state.
module multi_debouncer #(
   parameter int CHANNELS       = 4,
   parameter int CLK_FREQ_MHZ   = 50,
   parameter int GLITCH_TIME_NS = 1000,
   parameter int ACTIVE_LOW     = 0
) (
   input logic              clk_i,
   input logic              rst_n_i,
   multi_debouncer_if.slave bus
);
   localparam int G_CEIL = (GLITCH_TIME_NS * CLK_FREQ_MHZ + 999) / 1000;
   localparam int G      = (G_CEIL < 1) ? 1 : G_CEIL;
   localparam int CNT_W  = (G > 1) ? $clog2(G) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(G - 1);
   localparam logic INV  = (ACTIVE_LOW != 0);

   logic [CHANNELS-1:0] press_d_vec;
   logic                any_d;
   logic                any_q;

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic             s1_d, s1_q;
      logic             s2_d, s2_q;
      logic             state_d, state_q;
      logic             press_d, press_q;
      logic             rel_d, rel_q;
      logic [CNT_W-1:0] cnt_d, cnt_q;

      // Any sample agreeing with the held state discards all accumulated credit.
      always_comb begin
         s1_d    = bus.key_i[gi] ^ INV;
         s2_d    = s1_q;
         state_d = state_q;
         cnt_d   = '0;
         press_d = 1'b0;
         rel_d   = 1'b0;
         if (s2_q != state_q) begin
            if (cnt_q == CNT_MAX) begin
               state_d = s2_q;
               press_d = s2_q;
               rel_d   = ~s2_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end

      always_ff @(posedge clk_i or negedge rst_n_i) begin
         if (!rst_n_i) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            cnt_q   <= '0;
         end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            cnt_q   <= cnt_d;
         end
      end

      assign press_d_vec[gi]            = press_d;
      assign bus.key_state_o[gi]        = state_q;
      assign bus.key_pressed_stb_o[gi]  = press_q;
      assign bus.key_released_stb_o[gi] = rel_q;
   end

   // Registered from the same next-state terms so it lines up with the per-channel strobes.
   always_comb begin
      any_d = |press_d_vec;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         any_q <= 1'b0;
      end else begin
         any_q <= any_d;
      end
   end

   assign bus.any_pressed_stb_o = any_q;
endmodule

// File: tb/tb_multi_debouncer.sv
// Self-checking bench for multi_debouncer: three instances (G=5 active-high, G=5 active-low,
// G=3 single channel), table-driven vectors with a strobe scoreboard plus directed corner cases.
module tb_multi_debouncer;
   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   bit   sb_en = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   multi_debouncer_if #(.CHANNELS(4)) bus0 ();
   multi_debouncer_if #(.CHANNELS(4)) bus1 ();
   multi_debouncer_if #(.CHANNELS(1)) bus2 ();

   multi_debouncer #(.CHANNELS(4), .CLK_FREQ_MHZ(10), .GLITCH_TIME_NS(500), .ACTIVE_LOW(0))
      dut0 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus0));
   multi_debouncer #(.CHANNELS(4), .CLK_FREQ_MHZ(10), .GLITCH_TIME_NS(500), .ACTIVE_LOW(1))
      dut1 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus1));
   multi_debouncer #(.CHANNELS(1), .CLK_FREQ_MHZ(10), .GLITCH_TIME_NS(250), .ACTIVE_LOW(0))
      dut2 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus2));

   // G = 5 for dut0/dut1 (10 MHz, 500 ns); G = ceil(2.5) = 3 for dut2. Latency is G+2 edges.
   localparam int G0   = 5;
   localparam int LAT0 = 7;
   localparam int LAT2 = 5;

   logic [7:0] cnt_mon [4];
   for (genvar gi = 0; gi < 4; gi++) begin : g_mon
      assign cnt_mon[gi] = 8'(dut0.g_ch[gi].cnt_q);
   end

   typedef struct {
      int         cyc;
      int         dut;
      logic [3:0] press;
      logic [3:0] rel;
   } ev_t;
   ev_t exp_q[$];

   typedef struct {
      int         dut;
      logic [3:0] key;
      int         hold;
      logic [3:0] press;
      logic [3:0] rel;
      logic [3:0] state;
   } vec_t;
   vec_t vecs[14];

   int last_stb[4];

   function automatic int lat_of(int d);
      return (d == 2) ? LAT2 : LAT0;
   endfunction

   function automatic logic [3:0] get_state(int d);
      if (d == 0) return bus0.key_state_o;
      if (d == 1) return bus1.key_state_o;
      return {3'b000, bus2.key_state_o};
   endfunction

   function automatic logic [3:0] get_press(int d);
      if (d == 0) return bus0.key_pressed_stb_o;
      if (d == 1) return bus1.key_pressed_stb_o;
      return {3'b000, bus2.key_pressed_stb_o};
   endfunction

   function automatic logic [3:0] get_rel(int d);
      if (d == 0) return bus0.key_released_stb_o;
      if (d == 1) return bus1.key_released_stb_o;
      return {3'b000, bus2.key_released_stb_o};
   endfunction

   function automatic logic get_any(int d);
      if (d == 0) return bus0.any_pressed_stb_o;
      if (d == 1) return bus1.any_pressed_stb_o;
      return bus2.any_pressed_stb_o;
   endfunction

   task automatic set_key(int d, logic [3:0] v);
      if (d == 0) bus0.key_i = v;
      else if (d == 1) bus1.key_i = v;
      else bus2.key_i = v[0];
   endtask

   task automatic check4(string name, logic [3:0] act, logic [3:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%b required=%b", name, cyc, act, req);
      end
   endtask

   task automatic push_ev(int at, int d, logic [3:0] p, logic [3:0] r);
      ev_t e;
      if ((p | r) != 4'b0000) begin
         e.cyc = at; e.dut = d; e.press = p; e.rel = r;
         exp_q.push_back(e);
      end
   endtask

   // Waits so the last driven key value is held exactly `hold` cycles, then checks state.
   task automatic hold_check(int hold, int d, logic [3:0] st, string name);
      repeat (hold - 1) @(posedge clk);
      @(negedge clk);
      check4(name, get_state(d), st);
   endtask

   task automatic step(int d, logic [3:0] v, logic [3:0] p, logic [3:0] r);
      @(posedge clk); #1;
      set_key(d, v);
      push_ev(cyc + lat_of(d), d, p, r);
   endtask

   task automatic monitor();
      logic [3:0] ep[3];
      logic [3:0] er[3];
      logic [3:0] p;
      logic [3:0] r;
      logic       a;
      ev_t        e;
      forever begin
         @(negedge clk);
         if (sb_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
               e = exp_q.pop_front();
               checks++;
               failures++;
               $display("FAIL sb_missing dut%0d cycle=%0d actual=none required=press %b rel %b at %0d",
                        e.dut, cyc, e.press, e.rel, e.cyc);
            end
            for (int d = 0; d < 3; d++) begin
               ep[d] = 4'b0000;
               er[d] = 4'b0000;
            end
            while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
               e = exp_q.pop_front();
               ep[e.dut] = ep[e.dut] | e.press;
               er[e.dut] = er[e.dut] | e.rel;
            end
            for (int d = 0; d < 3; d++) begin
               p = get_press(d);
               r = get_rel(d);
               a = get_any(d);
               if ((p | r | ep[d] | er[d]) != 4'b0000 || a !== 1'b0) begin
                  checks++;
                  if (p !== ep[d] || r !== er[d] || a !== (|ep[d])) begin
                     failures++;
                     $display("FAIL sb_strobe dut%0d cycle=%0d actual=p%b r%b any%b required=p%b r%b any%b",
                              d, cyc, p, r, a, ep[d], er[d], |ep[d]);
                  end
               end
            end
         end
         for (int ch = 0; ch < 4; ch++) begin
            checks++;
            if (bus0.key_pressed_stb_o[ch] && bus0.key_released_stb_o[ch]) begin
               failures++;
               $display("FAIL both_strobes ch%0d cycle=%0d actual=11 required=not both", ch, cyc);
            end
            if (cnt_mon[ch] > 8'(G0 - 1)) begin
               failures++;
               $display("FAIL cnt_bound ch%0d cycle=%0d actual=%0d required<=%0d", ch, cyc, cnt_mon[ch], G0 - 1);
            end
            if (bus0.key_pressed_stb_o[ch] || bus0.key_released_stb_o[ch]) begin
               checks++;
               if (cyc - last_stb[ch] < G0) begin
                  failures++;
                  $display("FAIL stb_spacing ch%0d cycle=%0d actual=%0d required>=%0d",
                           ch, cyc, cyc - last_stb[ch], G0);
               end
               last_stb[ch] = cyc;
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] kb;
      int         nb;
      int         bounce[6];

      //          dut key      hold press    rel      state
      vecs[0]  = '{0, 4'b0001, 10, 4'b0001, 4'b0000, 4'b0001};
      vecs[1]  = '{0, 4'b0011,  4, 4'b0000, 4'b0000, 4'b0001};
      vecs[2]  = '{0, 4'b0001, 10, 4'b0000, 4'b0000, 4'b0001};
      vecs[3]  = '{0, 4'b0011,  5, 4'b0010, 4'b0000, 4'b0001};
      vecs[4]  = '{0, 4'b0001, 12, 4'b0000, 4'b0010, 4'b0001};
      vecs[5]  = '{0, 4'b0000, 10, 4'b0000, 4'b0001, 4'b0000};
      vecs[6]  = '{0, 4'b1111, 10, 4'b1111, 4'b0000, 4'b1111};
      vecs[7]  = '{0, 4'b0000, 10, 4'b0000, 4'b1111, 4'b0000};
      vecs[8]  = '{1, 4'b0000, 10, 4'b1111, 4'b0000, 4'b1111};
      vecs[9]  = '{1, 4'b1111, 10, 4'b0000, 4'b1111, 4'b0000};
      vecs[10] = '{2, 4'b0001,  2, 4'b0000, 4'b0000, 4'b0000};
      vecs[11] = '{2, 4'b0000,  8, 4'b0000, 4'b0000, 4'b0000};
      vecs[12] = '{2, 4'b0001,  3, 4'b0001, 4'b0000, 4'b0000};
      vecs[13] = '{2, 4'b0000, 10, 4'b0000, 4'b0001, 4'b0000};
      bounce = '{1, 0, 1, 1, 0, 1};

      for (int ch = 0; ch < 4; ch++) last_stb[ch] = -100;
      rst_n        = 1'b0;
      bus0.key_i   = 4'b0000;
      bus1.key_i   = 4'b1111;
      bus2.key_i   = 1'b0;
      fork
         monitor();
      join_none

      #12;
      for (int d = 0; d < 3; d++) begin
         check4($sformatf("reset_state_dut%0d", d), get_state(d), 4'b0000);
         check4($sformatf("reset_strobes_dut%0d", d), get_press(d) | get_rel(d) | {3'b000, get_any(d)}, 4'b0000);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      sb_en = 1'b1;

      for (int i = 0; i < 14; i++) begin
         step(vecs[i].dut, vecs[i].key, vecs[i].press, vecs[i].rel);
         hold_check(vecs[i].hold, vecs[i].dut, vecs[i].state, $sformatf("vec%0d_state", i));
      end

      // Bounce on channel 2: runs never reach G, so only the final settled 1 is accepted.
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         kb    = bus0.key_i;
         kb[2] = bounce[i][0];
         bus0.key_i = kb;
      end
      push_ev(cyc + LAT0, 0, 4'b0100, 4'b0000);
      hold_check(10, 0, 4'b0100, "bounce_state");
      step(0, 4'b0000, 4'b0000, 4'b0100);
      hold_check(10, 0, 4'b0000, "bounce_release");

      // Reset in the middle of a count, with another channel already pressed.
      step(0, 4'b0001, 4'b0001, 4'b0000);
      hold_check(10, 0, 4'b0001, "pre_reset_state");
      @(posedge clk); #1;
      bus0.key_i = 4'b1001;
      repeat (5) @(posedge clk);
      #2;
      check4("midcount_cnt", cnt_mon[3][3:0], 4'd3);
      rst_n = 1'b0;
      #1;
      check4("async_reset_state", bus0.key_state_o, 4'b0000);
      check4("async_reset_cnt", cnt_mon[3][3:0], 4'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      push_ev(cyc + LAT0, 0, 4'b1001, 4'b0000);
      hold_check(10, 0, 4'b1001, "held_through_reset");

      // Reset while a release strobe is high.
      step(0, 4'b1000, 4'b0000, 4'b0001);
      nb = cyc + LAT0;
      while (cyc < nb) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check4("midstrobe_rel", bus0.key_released_stb_o, 4'b0000);
      check4("midstrobe_state", bus0.key_state_o, 4'b0000);
      @(posedge clk); #1;
      rst_n = 1'b1;
      push_ev(cyc + LAT0, 0, 4'b1000, 4'b0000);
      hold_check(10, 0, 4'b1000, "press_after_reset");
      step(0, 4'b0000, 4'b0000, 4'b1000);
      hold_check(10, 0, 4'b0000, "final_release");

      // Random bouncing on every channel; only the continuous checks apply here.
      check4("sb_drained", 4'(exp_q.size()), 4'd0);
      sb_en = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #1;
         for (int ch = 0; ch < 4; ch++) begin
            if ($urandom_range(0, 3) == 0) bus0.key_i[ch] = ~bus0.key_i[ch];
            if ($urandom_range(0, 3) == 0) bus1.key_i[ch] = ~bus1.key_i[ch];
         end
         if ($urandom_range(0, 3) == 0) bus2.key_i = ~bus2.key_i;
      end
      @(posedge clk); #1;
      bus0.key_i = 4'b0000;
      bus1.key_i = 4'b1111;
      bus2.key_i = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check4($sformatf("settle_state_dut%0d", d), get_state(d), 4'b0000);
      end
      sb_en = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
